execute_m: RTL and testbench
============================

Name: execute_m

Overview:
- Next-generation execute stage for the pipelined RV32 core.
- Keeps the existing datapath:
  - rs1/rs2 forwarding muxes
  - immediate select
  - ALU and zero flag
  - branch/JALR target generation
- Adds an M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU):
  - multiply uses a parametrised pipelined multiplier
  - divide is iterative, 1 bit per cycle
- While an M op is in flight, asserts busy_e so the hazard unit holds F/D/E.

Parameters:
- D_WIDTH, 32: datapath width. Must be even and ≥8.
- MUL_LAT, 2: multiplier register stages, range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- alu_ctrl_e  in  4  ALU operation, same encoding as the current ALU
- alu_src_e  in  1  0 = forwarded rs2, 1 = imm_ext_e
- rd1_e  in  D_WIDTH  register file rs1 value
- rd2_e  in  D_WIDTH  register file rs2 value
- pc_e  in  D_WIDTH  instruction PC
- imm_ext_e  in  D_WIDTH  extended immediate
- funct3_e  in  3  funct3; selects the M op when muldiv_e = 1
- jalr_e  in  1  pc_target_e = ALU result when 1, else pc_e + imm_ext_e
- muldiv_e  in  1  instruction in E is an M-extension op
- flush_e  in  1  E-stage flush (branch mispredict)
- result_w  in  D_WIDTH  forward source, sel = 01
- alu_result_m  in  D_WIDTH  forward source, sel = 10
- fwd_rs1, fwd_rs2  in  2 each  forward selects; sel = 11 gives 0
- zero_e  out  1  ALU equality flag
- alu_result_e  out  D_WIDTH  ALU result, or M result when the M op completes
- write_data_e  out  D_WIDTH  forwarded rs2 (store data)
- pc_target_e  out  D_WIDTH  branch/jump target
- busy_e  out  1  stall request

Behaviour:
- Combinational path (muldiv_e = 0):
  - src_a = fwd mux(rs1); src_b = alu_src_e ? imm : fwd mux(rs2).
  - write_data_e = fwd mux(rs2); outputs identical to the single-cycle execute.
- FSM states: IDLE, MUL, DIV, DONE. Reset → IDLE, result register = 0, counter = 0.
- Start condition: IDLE, muldiv_e = 1, flush_e = 0.
  - busy_e = 1 combinationally in that same cycle.
  - Forwarded src_a and rs2 are latched into operand registers; forward sources change while E is held.
  - The funct3 op is latched alongside.
- MUL path (funct3[2] = 0):
  - Operands are sign/zero-extended to 2·D_WIDTH:
    - MULH: both signed
    - MULHSU: rs1 signed
    - MULHU, MUL: none
  - The product passes through MUL_LAT register stages while in MUL.
  - Result is the low half for MUL, the high half otherwise.
  - DONE is reached MUL_LAT+1 cycles after start.
- DIV path (funct3[2] = 1):
  - Signed ops take absolute values.
  - Restoring divide: D_WIDTH iterations in DIV, counter 0..D_WIDTH-1.
  - Sign fixup on exit: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - DONE is reached D_WIDTH+1 cycles after start.
- DIV special cases skip iteration; DONE is reached 1 cycle after start:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = most-negative, remainder = 0.
- DONE:
  - busy_e = 0; alu_result_e = result register; zero_e = 0.
  - Next state is IDLE unconditionally. The same instruction is leaving E, so no retrigger.
- busy_e = 1 in: the start cycle, MUL, and DIV. Otherwise 0.
- flush_e = 1 in any state: next state IDLE, no result produced, busy_e = 0 in that cycle.
- Async rst mid-operation: immediate return to IDLE; busy_e = 0; result register cleared.
- pc_target_e and write_data_e always reflect current inputs, not latched operands.
- All arithmetic wraps modulo 2^D_WIDTH.

Test Plan:
- ADD, fwd_rs1 = 10 with alu_result_m = 5, rd2 = 3, alu_src_e = 0 → alu_result_e = 8, busy_e = 0; jalr_e = 0, pc = 0x100, imm = 0x20 → pc_target_e = 0x120.
- MUL, rs1 = 7, rs2 = −3 (0xFFFFFFFD), MUL_LAT = 2 → busy_e high for 3 cycles, then alu_result_e = 0xFFFFFFEB for one cycle. MULHU of 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV, rs1 = −20, rs2 = 3 → busy_e high for 33 cycles; then DIV gives 0xFFFFFFFA (−6) and REM gives 0xFFFFFFFE (−2). DIVU of 100 by 7 gives 14.
- DIV by zero (rs1 = 42) → after 1 busy cycle: DIV = 0xFFFFFFFF, REM = 42. DIV 0x80000000 by 0xFFFFFFFF → 0x80000000; REM → 0.
- Operand latching: DIV starts with fwd_rs1 = 10, alu_result_m = 100; alu_result_m then changes to 0 during busy → result still 100 / rs2.
- Abort: assert flush_e at cycle 5 of a DIV → busy_e = 0 that cycle, FSM in IDLE next. Assert rst at cycle 10 of another DIV → busy_e = 0 immediately, alu_result_e follows the combinational ALU.

Source files
------------

// File: rtl/execute_m.sv
// RV32 execute stage: forwarding muxes, ALU, branch/JALR target, plus an
// M-extension unit (pipelined multiplier, 1-bit-per-cycle restoring divider).
module execute_m #(
  parameter int D_WIDTH = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         alu_ctrl_e,
  input  logic               alu_src_e,
  input  logic [D_WIDTH-1:0] rd1_e,
  input  logic [D_WIDTH-1:0] rd2_e,
  input  logic [D_WIDTH-1:0] pc_e,
  input  logic [D_WIDTH-1:0] imm_ext_e,
  input  logic [2:0]         funct3_e,
  input  logic               jalr_e,
  input  logic               muldiv_e,
  input  logic               flush_e,
  input  logic [D_WIDTH-1:0] result_w,
  input  logic [D_WIDTH-1:0] alu_result_m,
  input  logic [1:0]         fwd_rs1,
  input  logic [1:0]         fwd_rs2,
  output logic               zero_e,
  output logic [D_WIDTH-1:0] alu_result_e,
  output logic [D_WIDTH-1:0] write_data_e,
  output logic [D_WIDTH-1:0] pc_target_e,
  output logic               busy_e,
  output logic [1:0]         state_dbg
);

  localparam int W     = D_WIDTH;
  localparam int SH_W  = $clog2(W);
  localparam int CNT_W = SH_W;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_nx;

  logic [W-1:0] src_a, rs2_fwd, src_b, alu_out;
  logic [SH_W-1:0] shamt;

  // Forwarding muxes: 00 register file, 01 writeback, 10 memory stage, 11 zero.
  always_comb begin
    src_a = '0;
    case (fwd_rs1)
      2'b00:   src_a = rd1_e;
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = '0;
    endcase
    rs2_fwd = '0;
    case (fwd_rs2)
      2'b00:   rs2_fwd = rd2_e;
      2'b01:   rs2_fwd = result_w;
      2'b10:   rs2_fwd = alu_result_m;
      default: rs2_fwd = '0;
    endcase
  end

  assign src_b        = alu_src_e ? imm_ext_e : rs2_fwd;
  assign shamt        = src_b[SH_W-1:0];
  assign write_data_e = rs2_fwd;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl_e)
      ALU_ADD:  alu_out = src_a + src_b;
      ALU_SUB:  alu_out = src_a - src_b;
      ALU_AND:  alu_out = src_a & src_b;
      ALU_OR:   alu_out = src_a | src_b;
      ALU_XOR:  alu_out = src_a ^ src_b;
      ALU_SLT:  alu_out = W'($signed(src_a) < $signed(src_b));
      ALU_SLTU: alu_out = W'(src_a < src_b);
      ALU_SLL:  alu_out = src_a << shamt;
      ALU_SRL:  alu_out = src_a >> shamt;
      ALU_SRA:  alu_out = $signed(src_a) >>> shamt;
      default:  alu_out = '0;
    endcase
  end

  assign pc_target_e = jalr_e ? alu_out : (pc_e + imm_ext_e);

  // Start-cycle decode of the M op from the live (forwarded) operands.
  logic         start, f3_signed_div, div_zero, div_ovf;
  logic [W-1:0] abs_a, abs_b;

  assign start         = (state_q == IDLE) && muldiv_e && !flush_e && !rst;
  assign f3_signed_div = !funct3_e[0];
  assign div_zero      = (rs2_fwd == '0);
  assign div_ovf       = f3_signed_div && (src_a == MOST_NEG) && (rs2_fwd == '1);
  assign abs_a         = (f3_signed_div && src_a[W-1])   ? -src_a   : src_a;
  assign abs_b         = (f3_signed_div && rs2_fwd[W-1]) ? -rs2_fwd : rs2_fwd;

  logic [1:0]       op_q;
  logic [W-1:0]     op_a_q, op_b_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     quo_q, rem_q, dvs_q;
  logic             neg_q_q, neg_r_q;

  // Multiplier: sign-extend per op, keep the requested half of the product.
  logic             mul_a_s, mul_b_s;
  logic [2*W-1:0]   mul_a_x, mul_b_x, mul_prod;
  logic [W-1:0]     mul_sel, mul_tail;

  assign mul_a_s  = (op_q == 2'b01) || (op_q == 2'b10);
  assign mul_b_s  = (op_q == 2'b01);
  assign mul_a_x  = {{W{mul_a_s & op_a_q[W-1]}}, op_a_q};
  assign mul_b_x  = {{W{mul_b_s & op_b_q[W-1]}}, op_b_q};
  assign mul_prod = mul_a_x * mul_b_x;
  assign mul_sel  = (op_q == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];

  // MUL_LAT-1 pipeline registers; result_q forms the final stage.
  generate
    if (MUL_LAT > 1) begin : g_mul_pipe
      logic [W-1:0] pipe_q [MUL_LAT-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= mul_sel;
          for (int i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mul_tail = pipe_q[MUL_LAT-2];
    end else begin : g_mul_direct
      assign mul_tail = mul_sel;
    end
  endgenerate

  // One restoring-divide step on the unsigned magnitudes.
  logic [W:0]   div_shift, div_diff;
  logic [W-1:0] rem_nx, quo_nx, q_fix, r_fix, div_final;

  always_comb begin
    div_shift = {rem_q, quo_q[W-1]};
    div_diff  = div_shift - {1'b0, dvs_q};
    rem_nx    = div_shift[W-1:0];
    quo_nx    = {quo_q[W-2:0], 1'b0};
    if (!div_diff[W]) begin
      rem_nx = div_diff[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b1};
    end
    q_fix     = neg_q_q ? -quo_nx : quo_nx;
    r_fix     = neg_r_q ? -rem_nx : rem_nx;
    div_final = op_q[1] ? r_fix : q_fix;
  end

  // busy_e stalls F/D/E from the start cycle until the last MUL/DIV cycle;
  // a flush or reset drops it in the same cycle.
  always_comb begin
    state_nx = state_q;
    busy_e   = 1'b0;
    if (flush_e) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE: if (muldiv_e) begin
          busy_e = 1'b1;
          if (!funct3_e[2])           state_nx = MUL;
          else if (div_zero || div_ovf) state_nx = DONE;
          else                        state_nx = DIV;
        end
        MUL: begin
          busy_e = 1'b1;
          if (cnt_q == CNT_W'(MUL_LAT - 1)) state_nx = DONE;
        end
        DIV: begin
          busy_e = 1'b1;
          if (cnt_q == CNT_W'(W - 1)) state_nx = DONE;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
    if (rst) busy_e = 1'b0;
  end

  always_comb begin
    alu_result_e = alu_out;
    zero_e       = (alu_out == '0);
    if (state_q == DONE) begin
      alu_result_e = result_q;
      zero_e       = 1'b0;
    end
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else if (start) begin
      op_q    <= funct3_e[1:0];
      op_a_q  <= src_a;
      op_b_q  <= rs2_fwd;
      cnt_q   <= '0;
      quo_q   <= abs_a;
      rem_q   <= '0;
      dvs_q   <= abs_b;
      neg_q_q <= f3_signed_div && (src_a[W-1] ^ rs2_fwd[W-1]);
      neg_r_q <= f3_signed_div && src_a[W-1];
      if (funct3_e[2] && div_zero)
        result_q <= funct3_e[1] ? src_a : '1;
      else if (funct3_e[2] && div_ovf)
        result_q <= funct3_e[1] ? '0 : MOST_NEG;
    end else if (state_q == MUL && !flush_e) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(MUL_LAT - 1)) result_q <= mul_tail;
    end else if (state_q == DIV && !flush_e) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (cnt_q == CNT_W'(W - 1)) result_q <= div_final;
    end
  end

endmodule

// File: tb/tb_execute_m.sv
// Randomized bench for execute_m: a transaction-level model predicts every
// cycle's outputs, and one negedge process compares the DUT against it.
module tb_execute_m;

  localparam int W = 32;
  localparam int L = 2;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   alu_ctrl_e;
  logic         alu_src_e;
  logic [W-1:0] rd1_e, rd2_e, pc_e, imm_ext_e, result_w, alu_result_m;
  logic [2:0]   funct3_e;
  logic         jalr_e, muldiv_e, flush_e;
  logic [1:0]   fwd_rs1, fwd_rs2;
  logic         zero_e, busy_e;
  logic [W-1:0] alu_result_e, write_data_e, pc_target_e;
  logic [1:0]   state_dbg;

  execute_m #(.D_WIDTH(W), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
    .funct3_e(funct3_e), .jalr_e(jalr_e), .muldiv_e(muldiv_e), .flush_e(flush_e),
    .result_w(result_w), .alu_result_m(alu_result_m), .fwd_rs1(fwd_rs1),
    .fwd_rs2(fwd_rs2), .zero_e(zero_e), .alu_result_e(alu_result_e),
    .write_data_e(write_data_e), .pc_target_e(pc_target_e), .busy_e(busy_e),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Expectations
  logic         chk_en = 1'b0;
  logic         exp_busy, exp_done, exp_zero;
  logic [1:0]   exp_state;
  logic [W-1:0] exp_alu, exp_wd, exp_pct;
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic [W-1:0] fwd_m(input logic [1:0] sel, input logic [W-1:0] rf,
                                         input logic [W-1:0] rw, input logic [W-1:0] rm);
    case (sel)
      2'b00:   return rf;
      2'b01:   return rw;
      2'b10:   return rm;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] alu_m(input logic [3:0] ctrl, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (ctrl)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return 32'($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] m_model(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MIN && b == '1) return MIN;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == '1) return '0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int busy_cycles(input logic [2:0] f3, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (!f3[2]) return L + 1;
    if (b == 0 || (!f3[0] && a == MIN && b == '1)) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return MIN;
      3:       return '1;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Combinational expectations from the current inputs.
  task automatic upd_exp();
    logic [W-1:0] a, b2, b;
    a        = fwd_m(fwd_rs1, rd1_e, result_w, alu_result_m);
    b2       = fwd_m(fwd_rs2, rd2_e, result_w, alu_result_m);
    b        = alu_src_e ? imm_ext_e : b2;
    exp_alu  = alu_m(alu_ctrl_e, a, b);
    exp_zero = (exp_alu == 0);
    exp_wd   = b2;
    exp_pct  = jalr_e ? exp_alu : pc_e + imm_ext_e;
  endtask

  // Scoreboard / compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_e", 32'(busy_e), 32'(exp_busy));
      check("write_data_e", write_data_e, exp_wd);
      check("pc_target_e", pc_target_e, exp_pct);
      check("state_dbg", 32'(state_dbg), 32'(exp_state));
      if (exp_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL m_result: got %h expected <empty queue>", alu_result_e);
        end else begin
          check("m_result", alu_result_e, exp_q.pop_front());
        end
        check("zero_e_done", 32'(zero_e), 32'd0);
      end else begin
        check("alu_result_e", alu_result_e, exp_alu);
        check("zero_e", 32'(zero_e), 32'(exp_zero));
      end
    end
  end

  // Driver tasks
  task automatic rand_inputs();
    alu_ctrl_e   = 4'($urandom_range(0, 11));
    alu_src_e    = 1'($urandom_range(0, 1));
    rd1_e        = pick();
    rd2_e        = pick();
    pc_e         = $urandom;
    imm_ext_e    = pick();
    jalr_e       = 1'($urandom_range(0, 1));
    fwd_rs1      = 2'($urandom_range(0, 3));
    fwd_rs2      = 2'($urandom_range(0, 3));
    result_w     = pick();
    alu_result_m = pick();
    funct3_e     = 3'($urandom_range(0, 7));
    flush_e      = 1'b0;
  endtask

  task automatic run_alu();
    muldiv_e  = 1'b0;
    flush_e   = 1'b0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    exp_state = 2'd0;
    upd_exp();
    @(posedge clk); #1;
  endtask

  // Holds an M op in E for the model's busy time, then checks its result.
  task automatic run_m(input logic [2:0] f3, input int abort_at, input int abort_kind,
                       input logic latch_zero, input logic pin, input logic [W-1:0] lit);
    logic [W-1:0] a_op, b_op, e;
    int n;
    a_op = fwd_m(fwd_rs1, rd1_e, result_w, alu_result_m);
    b_op = fwd_m(fwd_rs2, rd2_e, result_w, alu_result_m);
    e    = m_model(f3, a_op, b_op);
    if (pin) check("model_pin", e, lit);
    n        = busy_cycles(f3, a_op, b_op);
    funct3_e = f3;
    muldiv_e = 1'b1;
    exp_done = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        if (latch_zero) alu_result_m = '0;
        else begin
          result_w     = $urandom;
          alu_result_m = $urandom;
        end
      end
      exp_state = (c == 0) ? 2'd0 : (f3[2] ? 2'd2 : 2'd1);
      if (c == abort_at) begin
        exp_busy = 1'b0;
        if (abort_kind == 0) flush_e = 1'b1;
        else begin
          rst       = 1'b1;
          exp_state = 2'd0;
        end
        upd_exp();
        @(posedge clk); #1;
        rst       = 1'b0;
        flush_e   = 1'b0;
        muldiv_e  = 1'b0;
        exp_state = 2'd0;
        upd_exp();
        @(posedge clk); #1;
        return;
      end
      exp_busy = 1'b1;
      upd_exp();
      @(posedge clk); #1;
    end
    result_w     = $urandom;
    alu_result_m = $urandom;
    exp_busy     = 1'b0;
    exp_done     = 1'b1;
    exp_state    = 2'd3;
    exp_q.push_back(e);
    upd_exp();
    @(posedge clk); #1;
    exp_done = 1'b0;
    muldiv_e = 1'b0;
  endtask

  task automatic set_m_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    rand_inputs();
    fwd_rs1 = 2'b00;
    fwd_rs2 = 2'b00;
    rd1_e   = a;
    rd2_e   = b;
  endtask

  // Main sequence
  initial begin
    rst = 1'b1;
    alu_ctrl_e = '0; alu_src_e = 1'b0; rd1_e = '0; rd2_e = '0; pc_e = '0;
    imm_ext_e = '0; funct3_e = '0; jalr_e = 1'b0; muldiv_e = 1'b0; flush_e = 1'b0;
    result_w = '0; alu_result_m = '0; fwd_rs1 = '0; fwd_rs2 = '0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_state = 2'd0;
    upd_exp();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADD with rs1 forwarded from M stage.
    rand_inputs();
    alu_ctrl_e = 4'd0; alu_src_e = 1'b0; rd1_e = 32'h55; rd2_e = 32'd3;
    fwd_rs1 = 2'b10; alu_result_m = 32'd5; fwd_rs2 = 2'b00;
    jalr_e = 1'b0; pc_e = 32'h100; imm_ext_e = 32'h20;
    upd_exp();
    check("pin_add", exp_alu, 32'd8);
    check("pin_pc_target", exp_pct, 32'h120);
    run_alu();

    set_m_ops(32'd7, 32'hFFFF_FFFD);        run_m(3'b000, -1, 0, 1'b0, 1'b1, 32'hFFFF_FFEB);
    set_m_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF); run_m(3'b011, -1, 0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    set_m_ops(32'hFFFF_FFEC, 32'd3);        run_m(3'b100, -1, 0, 1'b0, 1'b1, 32'hFFFF_FFFA);
    set_m_ops(32'hFFFF_FFEC, 32'd3);        run_m(3'b110, -1, 0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    set_m_ops(32'd100, 32'd7);              run_m(3'b101, -1, 0, 1'b0, 1'b1, 32'd14);
    set_m_ops(32'd42, 32'd0);               run_m(3'b100, -1, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    set_m_ops(32'd42, 32'd0);               run_m(3'b110, -1, 0, 1'b0, 1'b1, 32'd42);
    set_m_ops(MIN, 32'hFFFF_FFFF);          run_m(3'b100, -1, 0, 1'b0, 1'b1, MIN);
    set_m_ops(MIN, 32'hFFFF_FFFF);          run_m(3'b110, -1, 0, 1'b0, 1'b1, 32'd0);
    rand_inputs();
    run_alu();

    // Operand latching: forward source drops to 0 while the divide runs.
    rand_inputs();
    fwd_rs1 = 2'b10; alu_result_m = 32'd100; fwd_rs2 = 2'b00; rd2_e = 32'd7;
    run_m(3'b100, -1, 0, 1'b1, 1'b1, 32'd14);

    // Abort by flush, then by reset, then a clean op afterwards.
    set_m_ops(32'hFFFF_FFEC, 32'd3); run_m(3'b100, 5, 0, 1'b0, 1'b0, '0);
    set_m_ops(32'hFFFF_FFEC, 32'd3); run_m(3'b100, 10, 1, 1'b0, 1'b0, '0);
    set_m_ops(32'd9, 32'd6);         run_m(3'b000, -1, 0, 1'b0, 1'b1, 32'd54);

    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      if ($urandom_range(0, 2) == 0) run_alu();
      else begin
        rd1_e = pick();
        rd2_e = pick();
        if ($urandom_range(0, 7) == 0)
          run_m(funct3_e, int'($urandom_range(0, 8)), int'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
        else
          run_m(funct3_e, -1, 0, 1'b0, 1'b0, '0);
      end
    end
    rand_inputs();
    run_alu();

    chk_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
